pipe_rx_data: RTL and testbench
===============================

# pipe_rx_data

Receive-side PIPE data block: takes per-lane PHY receive data (RxData/RxDataK/RxValid/RxDataValid/RxStartBlock/RxSyncHeader/RxStatus) and delivers registered, block-aligned symbols to the lane descrambler. It is the receive counterpart of the PIPE transmit data mapper. In Gen1 mode it forwards 8b/10b symbols and flags decode errors. In Gen5 mode it tracks 128b/130b block boundaries, validates sync headers and gates data until block alignment is achieved.

## Interface
- pipe_width_gen1, 8, Gen1 PIPE data width (bits)
- pipe_width_gen5, 32, Gen5 PIPE data width (bits)
- BEATS_PER_BLOCK, 4, accepted Gen5 beats per 128-bit block (16 bytes / 4)
- ALIGN_GOOD, 2, consecutive good block starts required to declare alignment (1..7)
- ERR_CNT_W, 8, width of saturating error counter
- pclk  in  1  PIPE clock; all logic on rising edge
- reset_n  in  1  reset, synchronous, active-low
- generation  in  3  1 = Gen1, 5 = Gen5, other = disabled
- RxData  in  32  PHY receive data; Gen1 uses [7:0]
- RxDataK  in  4  K-symbol flags; Gen1 uses [0]
- RxValid  in  1  PHY symbol lock / data valid
- RxDataValid  in  1  Gen5 beat qualifier; ignored in Gen1
- RxStartBlock  in  1  Gen5 first beat of a block
- RxSyncHeader  in  2  Gen5 sync header, meaningful with RxStartBlock
- RxStatus  in  3  PIPE receive status
- descramblerDataIn  out  32  forwarded data
- descramblerDataK  out  4  forwarded K flags (Gen1 only, else 0)
- descramblerSyncHeader  out  2  header of current block (Gen5)
- descramblerStartBlock  out  1  forwarded beat is block start
- descramblerDataValid  out  1  forwarded beat qualifier
- blockAligned  out  1  Gen5 state == ALIGNED
- blockErr  out  1  one-cycle pulse, Gen5 framing error
- decodeErr  out  1  one-cycle pulse, Gen1 RxStatus error
- errCount  out  ERR_CNT_W  saturating count of error cycles

## Operation
- Beat accepted (Gen5) = RxValid && RxDataValid. Valid header = 2'b01 or 2'b10.
- Gen1: every cycle RxValid=1 forward RxData[7:0] (upper bits 0), RxDataK[0], DataValid=1; StartBlock/SyncHeader 0. decodeErr=1 when RxValid && RxStatus ∈ {3'b100, 3'b111}. blockAligned=0.
- Gen5 FSM states: UNALIGNED, CHECK, ALIGNED; beat counter beatCnt (0..BEATS_PER_BLOCK-1), goodCnt.
  - UNALIGNED: accepted beat with RxStartBlock && valid header -> CHECK, goodCnt=1, beatCnt=1 (if ALIGN_GOOD=1, go straight to ALIGNED). Other beats ignored, no error.
  - CHECK/ALIGNED, beatCnt==0 (expected start): RxStartBlock && valid header -> good block, goodCnt++ (sat), beatCnt=1; CHECK -> ALIGNED when goodCnt reaches ALIGN_GOOD. Missing RxStartBlock or invalid header -> blockErr, UNALIGNED, beatCnt=0.
  - CHECK/ALIGNED, beatCnt!=0: RxStartBlock=1 -> blockErr; if header valid restart as CHECK, goodCnt=1, beatCnt=1, else UNALIGNED. Otherwise beatCnt++ (wraps to 0 after BEATS_PER_BLOCK-1).
  - Accepted beat is forwarded (descramblerDataValid=1) iff next state is ALIGNED; descramblerSyncHeader latched from RxSyncHeader on each good start, held through block.
  - RxValid=0: -> UNALIGNED, beatCnt=0, goodCnt=0, no error. RxValid=1, RxDataValid=0: state/counters hold, DataValid=0.
- generation change (vs. value registered last cycle) or unsupported generation: FSM -> UNALIGNED, counters 0, all data outputs 0 that cycle.
- errCount += 1 on any cycle with blockErr or decodeErr (simultaneous counts once); saturates at all-ones; cleared only by reset.

## Timing
- All outputs registered; latency 1 pclk from input sample to output.
- Reset (reset_n=0 at rising edge): every output 0, FSM UNALIGNED, beatCnt/goodCnt/errCount 0, generation register 0. Reset mid-block discards the block; no error reported.
- blockErr/decodeErr are single-cycle pulses, aligned with the corresponding (non-forwarded) output cycle.
- Priority per cycle: reset > generation change/unsupported > RxValid=0 > RxDataValid=0 > FSM rules.

## Test plan
- Gen1: RxData=0x000000BC, RxDataK=1, RxValid=1 -> next cycle descramblerDataIn=0xBC, DataK=4'b0001, DataValid=1; RxStatus=3'b100 -> decodeErr pulse, errCount=1.
- Gen5 alignment: 3 clean blocks (header 2'b10, 4 beats each) -> block 1 dropped, blockAligned rises with beat 0 of block 2, DataValid=1 for 8 beats, SyncHeader=2'b10.
- Gen5 misframe: while ALIGNED, RxStartBlock=1 at beatCnt=2 with header 01 -> blockErr pulse, blockAligned=0, state CHECK, re-align after next good start.
- Gen5 invalid header 2'b11 at expected start -> blockErr, UNALIGNED, DataValid=0 until ALIGN_GOOD good blocks.
- Stall: RxDataValid=0 for 1 cycle mid-block -> no count advance, DataValid=0 that cycle, block completes without error.
- Reset/generation change mid-block -> all outputs 0 next cycle, errCount unchanged (gen change) or 0 (reset); 300 errors -> errCount=255.

Source files
------------

// File: rtl/pipe_rx_data_if.sv
// Bundles the PHY receive-side PIPE signals and the descrambler-facing results
// of pipe_rx_data.
//   master : PHY/stimulus view. Drives Rx* and observes the descrambler/status outputs.
//   slave  : pipe_rx_data view. Samples Rx* and drives the descrambler/status outputs.
interface pipe_rx_data_if #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ERR_CNT_W = 8
) ();
    // PHY receive side
    logic [DATA_W-1:0]    RxData;
    logic [3:0]           RxDataK;
    logic                 RxValid;
    logic                 RxDataValid;
    logic                 RxStartBlock;
    logic [1:0]           RxSyncHeader;
    logic [2:0]           RxStatus;

    // Descrambler side and status
    logic [DATA_W-1:0]    descramblerDataIn;
    logic [3:0]           descramblerDataK;
    logic [1:0]           descramblerSyncHeader;
    logic                 descramblerStartBlock;
    logic                 descramblerDataValid;
    logic                 blockAligned;
    logic                 blockErr;
    logic                 decodeErr;
    logic [ERR_CNT_W-1:0] errCount;

    modport master (
        output RxData, RxDataK, RxValid, RxDataValid, RxStartBlock, RxSyncHeader, RxStatus,
        input  descramblerDataIn, descramblerDataK, descramblerSyncHeader,
               descramblerStartBlock, descramblerDataValid,
               blockAligned, blockErr, decodeErr, errCount
    );

    modport slave (
        input  RxData, RxDataK, RxValid, RxDataValid, RxStartBlock, RxSyncHeader, RxStatus,
        output descramblerDataIn, descramblerDataK, descramblerSyncHeader,
               descramblerStartBlock, descramblerDataValid,
               blockAligned, blockErr, decodeErr, errCount
    );
endinterface

// File: rtl/pipe_rx_data.sv
// Receive-side PIPE data block. It forwards Gen1 8b/10b symbols and flags decode
// errors. In Gen5 it tracks 128b/130b block framing and gates data until blocks
// are aligned. Every output is registered, with a latency of one pclk.
//   pclk       : clock, rising edge
//   reset_n    : synchronous, active-low reset
//   generation : 1 = Gen1, 5 = Gen5, any other value = disabled
//   rx_if      : PHY Rx* inputs, descrambler outputs, blockAligned/blockErr/decodeErr/errCount
module pipe_rx_data #(
    parameter int unsigned pipe_width_gen1 = 8,
    parameter int unsigned pipe_width_gen5 = 32,
    parameter int unsigned BEATS_PER_BLOCK = 4,
    parameter int unsigned ALIGN_GOOD      = 2,
    parameter int unsigned ERR_CNT_W       = 8
) (
    input  logic          pclk,
    input  logic          reset_n,
    input  logic [2:0]    generation,
    pipe_rx_data_if.slave rx_if
);
    localparam int unsigned BEAT_W = (BEATS_PER_BLOCK > 1) ? $clog2(BEATS_PER_BLOCK) : 1;
    localparam int unsigned GOOD_W = 3;
    localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(BEATS_PER_BLOCK - 1);
    // Beat index that follows a block start. It is 0 again when a block has one beat.
    localparam logic [BEAT_W-1:0] BEAT_AFTER = (BEATS_PER_BLOCK > 1) ? BEAT_W'(1) : '0;
    localparam logic [GOOD_W-1:0] GOOD_TGT   = GOOD_W'(ALIGN_GOOD);
    localparam logic [2:0]        GEN1       = 3'd1;
    localparam logic [2:0]        GEN5       = 3'd5;

    typedef enum logic [1:0] {
        ST_UNALIGNED = 2'd0,
        ST_CHECK     = 2'd1,
        ST_ALIGNED   = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [BEAT_W-1:0]          beat_cnt_q, beat_cnt_d;
    logic [GOOD_W-1:0]          good_cnt_q, good_cnt_d;
    logic [2:0]                 gen_q, gen_d;
    logic [1:0]                 sync_hdr_q, sync_hdr_d;
    logic [pipe_width_gen5-1:0] data_q, data_d;
    logic [3:0]                 data_k_q, data_k_d;
    logic                       start_blk_q, start_blk_d;
    logic                       data_valid_q, data_valid_d;
    logic                       aligned_q, aligned_d;
    logic                       block_err_q, block_err_d;
    logic                       decode_err_q, decode_err_d;
    logic [ERR_CNT_W-1:0]       err_cnt_q, err_cnt_d;

    logic                       hdr_ok;
    logic [GOOD_W-1:0]          good_inc;
    logic [BEAT_W-1:0]          beat_next;
    logic                       unused_k;

    // Gen1 consumes only lane K bit 0. The upper K bits are sunk here.
    assign unused_k = ^rx_if.RxDataK[3:1];

    // State and output registers
    always_ff @(posedge pclk) begin
        if (!reset_n) begin
            state_q      <= ST_UNALIGNED;
            beat_cnt_q   <= '0;
            good_cnt_q   <= '0;
            gen_q        <= '0;
            sync_hdr_q   <= '0;
            data_q       <= '0;
            data_k_q     <= '0;
            start_blk_q  <= 1'b0;
            data_valid_q <= 1'b0;
            aligned_q    <= 1'b0;
            block_err_q  <= 1'b0;
            decode_err_q <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            good_cnt_q   <= good_cnt_d;
            gen_q        <= gen_d;
            sync_hdr_q   <= sync_hdr_d;
            data_q       <= data_d;
            data_k_q     <= data_k_d;
            start_blk_q  <= start_blk_d;
            data_valid_q <= data_valid_d;
            aligned_q    <= aligned_d;
            block_err_q  <= block_err_d;
            decode_err_q <= decode_err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    // Next state and outputs. Priority order: generation > RxValid > RxDataValid > framing.
    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        good_cnt_d   = good_cnt_q;
        sync_hdr_d   = sync_hdr_q;
        gen_d        = generation;
        data_d       = '0;
        data_k_d     = '0;
        start_blk_d  = 1'b0;
        data_valid_d = 1'b0;
        block_err_d  = 1'b0;
        decode_err_d = 1'b0;

        hdr_ok    = (rx_if.RxSyncHeader == 2'b01) || (rx_if.RxSyncHeader == 2'b10);
        good_inc  = (good_cnt_q == '1) ? good_cnt_q : good_cnt_q + GOOD_W'(1);
        beat_next = (beat_cnt_q == BEAT_LAST) ? '0 : beat_cnt_q + BEAT_W'(1);

        if ((generation != gen_q) || ((generation != GEN1) && (generation != GEN5))) begin
            state_d    = ST_UNALIGNED;
            beat_cnt_d = '0;
            good_cnt_d = '0;
            sync_hdr_d = '0;
        end else if (generation == GEN1) begin
            // Gen1 does not use block framing, so the framing state stays cleared.
            state_d    = ST_UNALIGNED;
            beat_cnt_d = '0;
            good_cnt_d = '0;
            sync_hdr_d = '0;
            if (rx_if.RxValid) begin
                data_d       = pipe_width_gen5'(rx_if.RxData[pipe_width_gen1-1:0]);
                data_k_d     = {3'b000, rx_if.RxDataK[0]};
                data_valid_d = 1'b1;
                decode_err_d = (rx_if.RxStatus == 3'b100) || (rx_if.RxStatus == 3'b111);
            end
        end else if (!rx_if.RxValid) begin
            state_d    = ST_UNALIGNED;
            beat_cnt_d = '0;
            good_cnt_d = '0;
            sync_hdr_d = '0;
        end else if (rx_if.RxDataValid) begin
            unique case (state_q)
                ST_UNALIGNED: begin
                    if (rx_if.RxStartBlock && hdr_ok) begin
                        good_cnt_d = GOOD_W'(1);
                        beat_cnt_d = BEAT_AFTER;
                        sync_hdr_d = rx_if.RxSyncHeader;
                        state_d    = (GOOD_TGT <= GOOD_W'(1)) ? ST_ALIGNED : ST_CHECK;
                    end
                end
                default: begin
                    if (beat_cnt_q == '0) begin
                        // A block start is expected on this beat.
                        if (rx_if.RxStartBlock && hdr_ok) begin
                            good_cnt_d = good_inc;
                            beat_cnt_d = BEAT_AFTER;
                            sync_hdr_d = rx_if.RxSyncHeader;
                            if ((state_q == ST_CHECK) && (good_inc >= GOOD_TGT)) begin
                                state_d = ST_ALIGNED;
                            end
                        end else begin
                            block_err_d = 1'b1;
                            state_d     = ST_UNALIGNED;
                            beat_cnt_d  = '0;
                            good_cnt_d  = '0;
                            sync_hdr_d  = '0;
                        end
                    end else if (rx_if.RxStartBlock) begin
                        // A start inside a block is a misframe. A valid header still opens a new block.
                        block_err_d = 1'b1;
                        if (hdr_ok) begin
                            state_d    = ST_CHECK;
                            good_cnt_d = GOOD_W'(1);
                            beat_cnt_d = BEAT_AFTER;
                            sync_hdr_d = rx_if.RxSyncHeader;
                        end else begin
                            state_d    = ST_UNALIGNED;
                            good_cnt_d = '0;
                            beat_cnt_d = '0;
                            sync_hdr_d = '0;
                        end
                    end else begin
                        beat_cnt_d = beat_next;
                    end
                end
            endcase

            if (state_d == ST_ALIGNED) begin
                data_d       = rx_if.RxData;
                start_blk_d  = rx_if.RxStartBlock;
                data_valid_d = 1'b1;
            end
        end

        aligned_d = (state_d == ST_ALIGNED);
        err_cnt_d = ((block_err_d || decode_err_d) && (err_cnt_q != '1))
                    ? err_cnt_q + ERR_CNT_W'(1) : err_cnt_q;
    end

    assign rx_if.descramblerDataIn     = data_q;
    assign rx_if.descramblerDataK      = data_k_q;
    assign rx_if.descramblerSyncHeader = sync_hdr_q;
    assign rx_if.descramblerStartBlock = start_blk_q;
    assign rx_if.descramblerDataValid  = data_valid_q;
    assign rx_if.blockAligned          = aligned_q;
    assign rx_if.blockErr              = block_err_q;
    assign rx_if.decodeErr             = decode_err_q;
    assign rx_if.errCount              = err_cnt_q;
endmodule

// File: tb/tb_pipe_rx_data.sv
// Self-checking bench for pipe_rx_data. A table of stimulus records and expected
// outputs is applied one record per cycle. Each expectation goes into a scoreboard
// queue when its stimulus is driven, and it is popped and compared 1 ns after
// the next rising edge.
module tb_pipe_rx_data;
    localparam int unsigned ERR_CNT_W = 8;

    logic       pclk = 1'b0;
    logic       reset_n;
    logic [2:0] generation;

    pipe_rx_data_if #(.DATA_W(32), .ERR_CNT_W(ERR_CNT_W)) bus ();

    pipe_rx_data #(
        .pipe_width_gen1(8),
        .pipe_width_gen5(32),
        .BEATS_PER_BLOCK(4),
        .ALIGN_GOOD     (2),
        .ERR_CNT_W      (ERR_CNT_W)
    ) dut (
        .pclk      (pclk),
        .reset_n   (reset_n),
        .generation(generation),
        .rx_if     (bus)
    );

    always #5 pclk = ~pclk;

    typedef struct packed {
        logic [2:0]  gen;
        logic        valid;
        logic        dv;
        logic        sb;
        logic [1:0]  hdr;
        logic [31:0] data;
        logic [3:0]  k;
        logic [2:0]  status;
    } in_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  k;
        logic [1:0]  hdr;
        logic        sb;
        logic        dv;
        logic        aligned;
        logic        berr;
        logic        derr;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    typedef struct packed {
        out_t                 o;
        logic [ERR_CNT_W-1:0] cnt;
    } exp_t;

    exp_t                 sb_q[$];
    vec_t                 tbl[$];
    int                   checks = 0;
    int                   errors = 0;
    logic [ERR_CNT_W-1:0] exp_cnt = '0;

    function automatic in_t mk_in(input logic [2:0] gen, input logic valid, input logic dv,
                                  input logic sb, input logic [1:0] hdr, input logic [31:0] data,
                                  input logic [3:0] k, input logic [2:0] status);
        in_t r;
        r.gen = gen; r.valid = valid; r.dv = dv; r.sb = sb; r.hdr = hdr;
        r.data = data; r.k = k; r.status = status;
        return r;
    endfunction

    function automatic out_t mk_out(input logic [31:0] data, input logic [3:0] k,
                                    input logic [1:0] hdr, input logic sb, input logic dv,
                                    input logic aligned, input logic berr, input logic derr);
        out_t r;
        r.data = data; r.k = k; r.hdr = hdr; r.sb = sb; r.dv = dv;
        r.aligned = aligned; r.berr = berr; r.derr = derr;
        return r;
    endfunction

    // Shorthands for Gen5 records
    function automatic in_t b5(input logic sb, input logic [1:0] hdr, input logic [31:0] data);
        return mk_in(3'd5, 1'b1, 1'b1, sb, hdr, data, 4'hF, 3'b000);
    endfunction
    function automatic out_t zero_o();
        return mk_out('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic out_t hold_o(input logic [1:0] hdr);
        return mk_out('0, '0, hdr, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic out_t fwd_o(input logic [31:0] data, input logic [1:0] hdr, input logic sb);
        return mk_out(data, '0, hdr, sb, 1'b1, 1'b1, 1'b0, 1'b0);
    endfunction

    function automatic vec_t v(input in_t i, input out_t o);
        vec_t r;
        r.i = i; r.o = o;
        return r;
    endfunction

    task automatic check(input string name);
        exp_t e;
        exp_t a;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e = sb_q.pop_front();
        a.o.data    = bus.descramblerDataIn;
        a.o.k       = bus.descramblerDataK;
        a.o.hdr     = bus.descramblerSyncHeader;
        a.o.sb      = bus.descramblerStartBlock;
        a.o.dv      = bus.descramblerDataValid;
        a.o.aligned = bus.blockAligned;
        a.o.berr    = bus.blockErr;
        a.o.derr    = bus.decodeErr;
        a.cnt       = bus.errCount;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got data=%h k=%b hdr=%b sb=%b dv=%b al=%b berr=%b derr=%b cnt=%0d, want data=%h k=%b hdr=%b sb=%b dv=%b al=%b berr=%b derr=%b cnt=%0d",
                     name, a.o.data, a.o.k, a.o.hdr, a.o.sb, a.o.dv, a.o.aligned, a.o.berr, a.o.derr, a.cnt,
                     e.o.data, e.o.k, e.o.hdr, e.o.sb, e.o.dv, e.o.aligned, e.o.berr, e.o.derr, e.cnt);
        end
    endtask

    task automatic apply(input vec_t vv, input string name);
        exp_t e;
        generation       = vv.i.gen;
        bus.RxValid      = vv.i.valid;
        bus.RxDataValid  = vv.i.dv;
        bus.RxStartBlock = vv.i.sb;
        bus.RxSyncHeader = vv.i.hdr;
        bus.RxData       = vv.i.data;
        bus.RxDataK      = vv.i.k;
        bus.RxStatus     = vv.i.status;
        if ((vv.o.berr || vv.o.derr) && (exp_cnt != '1)) exp_cnt = exp_cnt + ERR_CNT_W'(1);
        e.o   = vv.o;
        e.cnt = exp_cnt;
        sb_q.push_back(e);
        @(posedge pclk);
        #1;
        check(name);
    endtask

    task automatic do_reset(input string name);
        exp_t e;
        reset_n = 1'b0;
        exp_cnt = '0;
        e.o     = zero_o();
        e.cnt   = '0;
        sb_q.push_back(e);
        @(posedge pclk);
        #1;
        check(name);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n          = 1'b0;
        generation       = 3'd1;
        bus.RxValid      = 1'b1;
        bus.RxDataValid  = 1'b1;
        bus.RxStartBlock = 1'b1;
        bus.RxSyncHeader = 2'b10;
        bus.RxData       = 32'hDEADBEEF;
        bus.RxDataK      = 4'hF;
        bus.RxStatus     = 3'b100;

        // Gen1 forwarding and decode errors. The first Gen1 cycle is a generation change.
        tbl.push_back(v(mk_in(3'd1, 1, 0, 0, 2'b00, 32'h000000BC, 4'b0001, 3'b000), zero_o()));
        tbl.push_back(v(mk_in(3'd1, 1, 0, 0, 2'b00, 32'h000000BC, 4'b0001, 3'b000),
                        mk_out(32'hBC, 4'b0001, 2'b00, 0, 1, 0, 0, 0)));
        tbl.push_back(v(mk_in(3'd1, 1, 1, 0, 2'b00, 32'h12345655, 4'b1110, 3'b000),
                        mk_out(32'h55, 4'b0000, 2'b00, 0, 1, 0, 0, 0)));
        tbl.push_back(v(mk_in(3'd1, 1, 1, 0, 2'b00, 32'h000000BC, 4'b0001, 3'b100),
                        mk_out(32'hBC, 4'b0001, 2'b00, 0, 1, 0, 0, 1)));
        tbl.push_back(v(mk_in(3'd1, 1, 1, 0, 2'b00, 32'h0000001C, 4'b0001, 3'b111),
                        mk_out(32'h1C, 4'b0001, 2'b00, 0, 1, 0, 0, 1)));
        tbl.push_back(v(mk_in(3'd1, 0, 1, 0, 2'b00, 32'h000000BC, 4'b0001, 3'b100), zero_o()));
        tbl.push_back(v(mk_in(3'd1, 1, 1, 1, 2'b10, 32'h000000F7, 4'b0001, 3'b101),
                        mk_out(32'hF7, 4'b0001, 2'b00, 0, 1, 0, 0, 0)));
        // Switch to Gen5. Unaligned beats and bad-header starts are ignored.
        tbl.push_back(v(mk_in(3'd5, 0, 0, 0, 2'b00, 32'h0, 4'h0, 3'b000), zero_o()));
        tbl.push_back(v(b5(0, 2'b10, 32'h11111111), zero_o()));
        tbl.push_back(v(b5(1, 2'b00, 32'h22222222), zero_o()));
        // Block A is dropped while checking. Blocks B and C are forwarded.
        tbl.push_back(v(b5(1, 2'b10, 32'hA0A0A0A0), hold_o(2'b10)));
        for (int b = 1; b < 4; b++) tbl.push_back(v(b5(0, 2'b11, 32'hA0A0A0A0 + b), hold_o(2'b10)));
        for (int b = 0; b < 4; b++)
            tbl.push_back(v(b5(b == 0, 2'b10, 32'hB0B0B0B0 + b), fwd_o(32'hB0B0B0B0 + b, 2'b10, b == 0)));
        for (int b = 0; b < 4; b++)
            tbl.push_back(v(b5(b == 0, 2'b10, 32'hC0C0C0C0 + b), fwd_o(32'hC0C0C0C0 + b, 2'b10, b == 0)));
        // Block D has a one-cycle RxDataValid stall after beat 1.
        tbl.push_back(v(b5(1, 2'b10, 32'hD0000000), fwd_o(32'hD0000000, 2'b10, 1)));
        tbl.push_back(v(b5(0, 2'b10, 32'hD0000001), fwd_o(32'hD0000001, 2'b10, 0)));
        tbl.push_back(v(mk_in(3'd5, 1, 0, 1, 2'b11, 32'hBADBAD00, 4'h0, 3'b000),
                        mk_out('0, '0, 2'b10, 0, 0, 1, 0, 0)));
        tbl.push_back(v(b5(0, 2'b10, 32'hD0000002), fwd_o(32'hD0000002, 2'b10, 0)));
        tbl.push_back(v(b5(0, 2'b10, 32'hD0000003), fwd_o(32'hD0000003, 2'b10, 0)));
        // Block E has a misframed start with a valid header at beat 2, which restarts checking.
        tbl.push_back(v(b5(1, 2'b10, 32'hE0000000), fwd_o(32'hE0000000, 2'b10, 1)));
        tbl.push_back(v(b5(0, 2'b10, 32'hE0000001), fwd_o(32'hE0000001, 2'b10, 0)));
        tbl.push_back(v(b5(1, 2'b01, 32'hF0000000), mk_out('0, '0, 2'b01, 0, 0, 0, 1, 0)));
        for (int b = 1; b < 4; b++) tbl.push_back(v(b5(0, 2'b00, 32'hF0000000 + b), hold_o(2'b01)));
        for (int b = 0; b < 4; b++)
            tbl.push_back(v(b5(b == 0, 2'b01, 32'h60000000 + b), fwd_o(32'h60000000 + b, 2'b01, b == 0)));
        // An invalid header at the expected start drops alignment. Realigning takes two good blocks.
        tbl.push_back(v(b5(1, 2'b11, 32'h70000000), mk_out('0, '0, 2'b00, 0, 0, 0, 1, 0)));
        tbl.push_back(v(b5(0, 2'b10, 32'h70000001), zero_o()));
        tbl.push_back(v(b5(1, 2'b10, 32'h80000000), hold_o(2'b10)));
        for (int b = 1; b < 4; b++) tbl.push_back(v(b5(0, 2'b10, 32'h80000000 + b), hold_o(2'b10)));
        for (int b = 0; b < 4; b++)
            tbl.push_back(v(b5(b == 0, 2'b10, 32'h90000000 + b), fwd_o(32'h90000000 + b, 2'b10, b == 0)));
        // A missing start at the expected position is an error. Loss of RxValid clears framing silently.
        tbl.push_back(v(b5(0, 2'b10, 32'h99999999), mk_out('0, '0, 2'b00, 0, 0, 0, 1, 0)));
        tbl.push_back(v(b5(1, 2'b10, 32'hAA000000), hold_o(2'b10)));
        tbl.push_back(v(mk_in(3'd5, 0, 1, 0, 2'b10, 32'hAA000001, 4'h0, 3'b000), zero_o()));
        tbl.push_back(v(b5(0, 2'b10, 32'hAA000002), zero_o()));

        do_reset("reset_state");
        foreach (tbl[n]) apply(tbl[n], $sformatf("tbl[%0d]", n));

        // Generation change mid-block clears outputs but keeps errCount (5 here).
        apply(v(b5(1, 2'b10, 32'h01000000), hold_o(2'b10)), "gc_chk0");
        for (int b = 1; b < 4; b++) apply(v(b5(0, 2'b10, 32'h01000000 + b), hold_o(2'b10)), "gc_chk");
        apply(v(b5(1, 2'b10, 32'h02000000), fwd_o(32'h02000000, 2'b10, 1)), "gc_aln0");
        apply(v(b5(0, 2'b10, 32'h02000001), fwd_o(32'h02000001, 2'b10, 0)), "gc_aln1");
        apply(v(mk_in(3'd1, 1, 1, 0, 2'b00, 32'hBC, 4'b0001, 3'b100), zero_o()), "gen_to_1");
        apply(v(b5(1, 2'b10, 32'h03000000), zero_o()), "gen_to_5");
        apply(v(b5(1, 2'b10, 32'h04000000), hold_o(2'b10)), "gen5_restart");
        if (exp_cnt != ERR_CNT_W'(5)) begin
            errors++;
            $display("FAIL err_total: bench count %0d, want 5", exp_cnt);
        end
        checks++;

        // A reset mid-block clears everything, including errCount.
        do_reset("reset_midblock");
        apply(v(b5(1, 2'b10, 32'h05000000), zero_o()), "post_reset_gen5");

        // Unsupported generation is held at zero.
        apply(v(mk_in(3'd7, 1, 1, 0, 2'b00, 32'hBC, 4'b0001, 3'b100), zero_o()), "gen7_a");
        apply(v(mk_in(3'd7, 1, 1, 0, 2'b00, 32'hBC, 4'b0001, 3'b100), zero_o()), "gen7_b");

        // errCount saturates after 300 Gen1 decode errors.
        apply(v(mk_in(3'd1, 1, 1, 0, 2'b00, 32'h0, 4'h0, 3'b100), zero_o()), "sat_genchg");
        for (int n = 0; n < 300; n++)
            apply(v(mk_in(3'd1, 1, 1, 0, 2'b00, 32'h0, 4'h0, 3'b100),
                    mk_out('0, '0, 2'b00, 0, 1, 0, 0, 1)), $sformatf("sat[%0d]", n));
        checks++;
        if (bus.errCount !== 8'd255) begin
            errors++;
            $display("FAIL sat_final: errCount=%0d, want 255", bus.errCount);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
